hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 30 +++
 rtl/hazard_match.sv | 31 +++
 rtl/hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_hazard_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: the scoreboard entry
// layout, the BUBBLE encodings and the forwarding-select encoding.
package hazard_ctrl_pkg;

  // Widest register address a scoreboard entry can hold (RA_W must not exceed it).
  localparam int SB_RA_W = 8;

  // One tracked in-flight instruction.
  typedef struct packed {
    logic               valid;
    logic [SB_RA_W-1:0] rd;
    logic               wen;
    logic               is_load;
  } sb_entry_t;

  // Empty slot: nothing in flight, never matches a source.
  localparam sb_entry_t SB_BUBBLE = '{valid: 1'b0, rd: '0, wen: 1'b0, is_load: 1'b0};

  // Instruction word the fetch stage inserts when IF/ID is flushed (addi x0, x0, 0).
  localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0013;

  // Forwarding select: 0 reads the register file, k+1 takes slot k.
  localparam int          FWD_SEL_W  = 3;
  localparam logic [2:0]  FWD_SEL_RF = 3'd0;

  function automatic logic [FWD_SEL_W-1:0] fwd_sel_slot(input logic [2:0] slot);
    return slot + 3'd1;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one ID source operand against every scoreboard slot. The youngest
// (lowest index) matching slot wins; x0 never matches.
module hazard_match
  import hazard_ctrl_pkg::*;
#(
  parameter int RA_W  = 5,
  parameter int DEPTH = 3
) (
  input  logic                  src_used,
  input  logic [RA_W-1:0]       src_addr,
  input  sb_entry_t [DEPTH-1:0] sb,
  output logic                  hit,
  output logic [2:0]            slot,
  output logic                  load_use
);

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    hit  = 1'b0;
    slot = 3'd0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (src_used && (src_addr != '0) && sb[k].valid && sb[k].wen &&
          (sb[k].rd == SB_RA_W'(src_addr))) begin
        hit  = 1'b1;
        slot = 3'(k);
      end
    end
    load_use = hit && (slot == 3'd0) && sb[0].is_load;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks in-flight destinations in a DEPTH-slot
// scoreboard and produces stall / flush / bubble controls plus operand
// forwarding selects.
// Build option: define HAZARD_FWD_EN to resolve hazards by forwarding (only a
// load-use stalls for one cycle); without it every dependency stalls until the
// producer has left the last slot and the forwarding outputs are tied to 0.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int DEPTH = 3,   // legal range 2..6
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [RA_W-1:0]       id_rs1_addr,
  input  logic [RA_W-1:0]       id_rs2_addr,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [RA_W-1:0]       id_rd_addr,
  input  logic                  id_rf_wen,
  input  logic                  id_is_load,
  input  logic                  ex_redirect,
  input  logic [DEPTH*XLEN-1:0] stage_data,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  flush_ifid,
  output logic                  bubble_ex,
  output logic [2:0]            rs1_fwd_sel,
  output logic [2:0]            rs2_fwd_sel,
  output logic [XLEN-1:0]       rs1_fwd_data,
  output logic [XLEN-1:0]       rs2_fwd_data,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  sb_entry_t [DEPTH-1:0] sb_q, sb_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;

  logic       rs1_hit, rs2_hit, rs1_lu, rs2_lu, hazard, stall;
  logic [2:0] rs1_slot, rs2_slot;

  hazard_match #(.RA_W(RA_W), .DEPTH(DEPTH)) u_match_rs1 (
    .src_used (id_valid & id_rs1_used),
    .src_addr (id_rs1_addr),
    .sb       (sb_q),
    .hit      (rs1_hit),
    .slot     (rs1_slot),
    .load_use (rs1_lu)
  );

  hazard_match #(.RA_W(RA_W), .DEPTH(DEPTH)) u_match_rs2 (
    .src_used (id_valid & id_rs2_used),
    .src_addr (id_rs2_addr),
    .sb       (sb_q),
    .hit      (rs2_hit),
    .slot     (rs2_slot),
    .load_use (rs2_lu)
  );

`ifdef HAZARD_FWD_EN
  assign hazard = rs1_lu | rs2_lu;
`else
  assign hazard = rs1_hit | rs2_hit;
  logic unused_nofwd;
  assign unused_nofwd = ^{stage_data, rs1_slot, rs2_slot, rs1_lu, rs2_lu};
`endif

  // A redirect squashes the ID instruction, so it overrides any stall; reset forces everything quiet.
  assign stall = hazard & ~ex_redirect & ~reset;

  // Pipeline control outputs, combinational from inputs and scoreboard.
  always_comb begin
    stall_if   = stall;
    stall_id   = stall;
    flush_ifid = ex_redirect & ~reset;
    bubble_ex  = stall | (ex_redirect & ~reset);
  end

  // Operand forwarding: take the youngest producer's result unless it is a load still in EX.
  always_comb begin
    rs1_fwd_sel  = FWD_SEL_RF;
    rs2_fwd_sel  = FWD_SEL_RF;
    rs1_fwd_data = '0;
    rs2_fwd_data = '0;
`ifdef HAZARD_FWD_EN
    if (!reset && rs1_hit && !rs1_lu) begin
      rs1_fwd_sel  = fwd_sel_slot(rs1_slot);
      rs1_fwd_data = stage_data[int'(rs1_slot)*XLEN +: XLEN];
    end
    if (!reset && rs2_hit && !rs2_lu) begin
      rs2_fwd_sel  = fwd_sel_slot(rs2_slot);
      rs2_fwd_data = stage_data[int'(rs2_slot)*XLEN +: XLEN];
    end
`endif
  end

  // Scoreboard advance and saturating performance counters.
  always_comb begin
    sb_d = sb_q;
    for (int k = DEPTH - 1; k >= 1; k--) begin
      sb_d[k] = sb_q[k-1];
    end
    if (id_valid && !stall && !ex_redirect) begin
      sb_d[0] = '{valid: 1'b1, rd: SB_RA_W'(id_rd_addr), wen: id_rf_wen, is_load: id_is_load};
    end else begin
      sb_d[0] = SB_BUBBLE;
    end
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (ex_redirect && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_q        <= {DEPTH{SB_BUBBLE}};
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      sb_q        <= sb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: a behavioural scoreboard model predicts every output
// each cycle (pushed at drive time, popped at the falling edge), and each
// scenario task adds its own directed checks against fixed values.
module tb_hazard_ctrl;

  localparam int XLEN  = 32;
  localparam int RA_W  = 5;
  localparam int DEPTH = 3;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

`ifdef HAZARD_FWD_EN
  localparam int LU_STALLS = 1;
`else
  localparam int LU_STALLS = DEPTH;
`endif

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  id_valid = 1'b0;
  logic [RA_W-1:0]       id_rs1_addr = '0, id_rs2_addr = '0, id_rd_addr = '0;
  logic                  id_rs1_used = 1'b0, id_rs2_used = 1'b0;
  logic                  id_rf_wen = 1'b0, id_is_load = 1'b0, ex_redirect = 1'b0;
  logic [DEPTH*XLEN-1:0] stage_data = '0;
  logic                  stall_if, stall_id, flush_ifid, bubble_ex;
  logic [2:0]            rs1_fwd_sel, rs2_fwd_sel;
  logic [XLEN-1:0]       rs1_fwd_data, rs2_fwd_data;
  logic [CNT_W-1:0]      stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.XLEN(XLEN), .RA_W(RA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd_addr(id_rd_addr), .id_rf_wen(id_rf_wen), .id_is_load(id_is_load),
    .ex_redirect(ex_redirect), .stage_data(stage_data),
    .stall_if(stall_if), .stall_id(stall_id), .flush_ifid(flush_ifid), .bubble_ex(bubble_ex),
    .rs1_fwd_sel(rs1_fwd_sel), .rs2_fwd_sel(rs2_fwd_sel),
    .rs1_fwd_data(rs1_fwd_data), .rs2_fwd_data(rs2_fwd_data),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct {
    logic            v;
    logic [RA_W-1:0] rd;
    logic            wen;
    logic            ld;
  } ment_t;

  typedef struct {
    logic             stall;
    logic             flush;
    logic             bubble;
    logic [2:0]       s1;
    logic [2:0]       s2;
    logic [XLEN-1:0]  d1;
    logic [XLEN-1:0]  d2;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
  } exp_t;

  ment_t m_sb [DEPTH];
  int    m_sc, m_fc, m_stalls_total;
  exp_t  exp_q [$];
  int    n_cmp = 0;
  int    n_fail = 0;
  logic  last_stall;

  function automatic void m_match(input logic used, input logic [RA_W-1:0] a,
                                  output logic hit, output int idx);
    hit = 1'b0;
    idx = 0;
    if (used && id_valid && a != '0) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (!hit && m_sb[k].v && m_sb[k].wen && m_sb[k].rd == a) begin
          hit = 1'b1;
          idx = k;
        end
      end
    end
  endfunction

  function automatic exp_t predict();
    exp_t e;
    logic h1, h2, haz;
    int   i1, i2;
    e = '{default: '0};
    if (reset) return e;
    m_match(id_rs1_used, id_rs1_addr, h1, i1);
    m_match(id_rs2_used, id_rs2_addr, h2, i2);
`ifdef HAZARD_FWD_EN
    begin
      logic lu1, lu2;
      lu1 = h1 && i1 == 0 && m_sb[0].ld;
      lu2 = h2 && i2 == 0 && m_sb[0].ld;
      haz = lu1 || lu2;
      if (h1 && !lu1) begin e.s1 = 3'(i1 + 1); e.d1 = stage_data[i1*XLEN +: XLEN]; end
      if (h2 && !lu2) begin e.s2 = 3'(i2 + 1); e.d2 = stage_data[i2*XLEN +: XLEN]; end
    end
`else
    haz = h1 || h2;
`endif
    e.stall  = haz && !ex_redirect;
    e.flush  = ex_redirect;
    e.bubble = e.stall || ex_redirect;
    e.sc     = m_sc[CNT_W-1:0];
    e.fc     = m_fc[CNT_W-1:0];
    return e;
  endfunction

  // One clock: predict, compare at the falling edge, advance the model, return just after the rising edge.
  task automatic run_cycle();
    exp_t e, g;
    e = predict();
    exp_q.push_back(e);
    @(negedge clk);
    g = exp_q.pop_front();
    n_cmp += 10;
    if (stall_if !== g.stall) begin n_fail++; $display("FAIL sb_stall_if: got %b want %b @%0t", stall_if, g.stall, $time); end
    if (stall_id !== g.stall) begin n_fail++; $display("FAIL sb_stall_id: got %b want %b @%0t", stall_id, g.stall, $time); end
    if (flush_ifid !== g.flush) begin n_fail++; $display("FAIL sb_flush_ifid: got %b want %b @%0t", flush_ifid, g.flush, $time); end
    if (bubble_ex !== g.bubble) begin n_fail++; $display("FAIL sb_bubble_ex: got %b want %b @%0t", bubble_ex, g.bubble, $time); end
    if (rs1_fwd_sel !== g.s1) begin n_fail++; $display("FAIL sb_rs1_sel: got %0d want %0d @%0t", rs1_fwd_sel, g.s1, $time); end
    if (rs2_fwd_sel !== g.s2) begin n_fail++; $display("FAIL sb_rs2_sel: got %0d want %0d @%0t", rs2_fwd_sel, g.s2, $time); end
    if (rs1_fwd_data !== g.d1) begin n_fail++; $display("FAIL sb_rs1_data: got %h want %h @%0t", rs1_fwd_data, g.d1, $time); end
    if (rs2_fwd_data !== g.d2) begin n_fail++; $display("FAIL sb_rs2_data: got %h want %h @%0t", rs2_fwd_data, g.d2, $time); end
    if (stall_cnt !== g.sc) begin n_fail++; $display("FAIL sb_stall_cnt: got %0d want %0d @%0t", stall_cnt, g.sc, $time); end
    if (flush_cnt !== g.fc) begin n_fail++; $display("FAIL sb_flush_cnt: got %0d want %0d @%0t", flush_cnt, g.fc, $time); end
    last_stall = g.stall;
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) m_sb[k] = '{v: 1'b0, rd: '0, wen: 1'b0, ld: 1'b0};
      m_sc = 0;
      m_fc = 0;
    end else begin
      if (g.stall) m_stalls_total++;
      if (g.stall && m_sc < CMAX) m_sc++;
      if (ex_redirect && m_fc < CMAX) m_fc++;
      for (int k = DEPTH - 1; k >= 1; k--) m_sb[k] = m_sb[k-1];
      if (id_valid && !g.stall && !ex_redirect)
        m_sb[0] = '{v: 1'b1, rd: id_rd_addr, wen: id_rf_wen, ld: id_is_load};
      else
        m_sb[0] = '{v: 1'b0, rd: '0, wen: 1'b0, ld: 1'b0};
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < DEPTH; k++) stage_data[k*XLEN +: XLEN] = $urandom;
  endtask

  task automatic set_id(input logic v, input logic [RA_W-1:0] r1, input logic u1,
                        input logic [RA_W-1:0] r2, input logic u2,
                        input logic [RA_W-1:0] rd, input logic wen, input logic ld);
    id_valid = v; id_rs1_addr = r1; id_rs1_used = u1; id_rs2_addr = r2; id_rs2_used = u2;
    id_rd_addr = rd; id_rf_wen = wen; id_is_load = ld;
  endtask

  task automatic idle();
    set_id(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    ex_redirect = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run_cycle();
    reset = 1'b0;
  endtask

  // Keep the current ID instruction presented until it issues.
  task automatic issue(input int max);
    int n;
    n = 0;
    run_cycle();
    while (last_stall && n < max) begin
      run_cycle();
      n++;
    end
    n_cmp++;
    if (last_stall) begin n_fail++; $display("FAIL issue_timeout: still stalled after %0d cycles, want issued", max); end
    idle();
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    set_id(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd3, 1'b1, 1'b1);
    ex_redirect = 1'b1;
    #1;
    n_cmp += 4;
    if (flush_ifid !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b want 0", flush_ifid); end
    if (bubble_ex !== 1'b0) begin n_fail++; $display("FAIL reset_bubble: got %b want 0", bubble_ex); end
    if (stall_cnt !== '0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
    if (flush_cnt !== '0) begin n_fail++; $display("FAIL reset_flush_cnt: got %0d want 0", flush_cnt); end
    run_cycle();
    run_cycle();
    reset = 1'b0;
    idle();
    run_cycle();
    run_cycle();
  endtask

  task automatic test_forward();
    do_reset();
    set_id(1'b1, '0, 1'b0, '0, 1'b0, 5'd5, 1'b1, 1'b0);
    run_cycle();
    set_id(1'b1, 5'd5, 1'b1, '0, 1'b0, 5'd9, 1'b1, 1'b0);
    stage_data[0 +: XLEN] = 32'h11;
    #1;
    n_cmp += 3;
`ifdef HAZARD_FWD_EN
    if (rs1_fwd_sel !== 3'd1) begin n_fail++; $display("FAIL fwd_sel: got %0d want 1", rs1_fwd_sel); end
    if (rs1_fwd_data !== 32'h11) begin n_fail++; $display("FAIL fwd_data: got %h want 11", rs1_fwd_data); end
    if (stall_id !== 1'b0) begin n_fail++; $display("FAIL fwd_stall: got %b want 0", stall_id); end
`else
    if (rs1_fwd_sel !== 3'd0) begin n_fail++; $display("FAIL fwd_sel: got %0d want 0", rs1_fwd_sel); end
    if (rs1_fwd_data !== '0) begin n_fail++; $display("FAIL fwd_data: got %h want 0", rs1_fwd_data); end
    if (stall_id !== 1'b1) begin n_fail++; $display("FAIL fwd_stall: got %b want 1", stall_id); end
`endif
    issue(10);
    run_cycle();
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1'b1, '0, 1'b0, '0, 1'b0, 5'd6, 1'b1, 1'b1);
    run_cycle();
    set_id(1'b1, '0, 1'b0, 5'd6, 1'b1, 5'd8, 1'b1, 1'b0);
    #1;
    n_cmp += 3;
    if (stall_id !== 1'b1) begin n_fail++; $display("FAIL lu_stall_id: got %b want 1", stall_id); end
    if (stall_if !== 1'b1) begin n_fail++; $display("FAIL lu_stall_if: got %b want 1", stall_if); end
    if (bubble_ex !== 1'b1) begin n_fail++; $display("FAIL lu_bubble: got %b want 1", bubble_ex); end
    run_cycle();
    n_cmp += 2;
`ifdef HAZARD_FWD_EN
    if (rs2_fwd_sel !== 3'd2) begin n_fail++; $display("FAIL lu_next_sel: got %0d want 2", rs2_fwd_sel); end
    if (stall_id !== 1'b0) begin n_fail++; $display("FAIL lu_next_stall: got %b want 0", stall_id); end
`else
    if (rs2_fwd_sel !== 3'd0) begin n_fail++; $display("FAIL lu_next_sel: got %0d want 0", rs2_fwd_sel); end
    if (stall_id !== 1'b1) begin n_fail++; $display("FAIL lu_next_stall: got %b want 1", stall_id); end
`endif
    issue(10);
    n_cmp++;
    if (stall_cnt !== CNT_W'(LU_STALLS)) begin n_fail++; $display("FAIL lu_stall_cnt: got %0d want %0d", stall_cnt, LU_STALLS); end
    run_cycle();
  endtask

  task automatic test_x0();
    do_reset();
    set_id(1'b1, '0, 1'b0, '0, 1'b0, 5'd0, 1'b1, 1'b0);
    run_cycle();
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0);
    #1;
    n_cmp += 3;
    if (rs1_fwd_sel !== 3'd0) begin n_fail++; $display("FAIL x0_rs1_sel: got %0d want 0", rs1_fwd_sel); end
    if (rs2_fwd_sel !== 3'd0) begin n_fail++; $display("FAIL x0_rs2_sel: got %0d want 0", rs2_fwd_sel); end
    if (stall_id !== 1'b0) begin n_fail++; $display("FAIL x0_stall: got %b want 0", stall_id); end
    run_cycle();
    idle();
    run_cycle();
  endtask

  task automatic test_redirect();
    do_reset();
    set_id(1'b1, '0, 1'b0, '0, 1'b0, 5'd6, 1'b1, 1'b1);
    run_cycle();
    set_id(1'b1, 5'd6, 1'b1, '0, 1'b0, 5'd2, 1'b1, 1'b0);
    ex_redirect = 1'b1;
    #1;
    n_cmp += 4;
    if (flush_ifid !== 1'b1) begin n_fail++; $display("FAIL rd_flush: got %b want 1", flush_ifid); end
    if (bubble_ex !== 1'b1) begin n_fail++; $display("FAIL rd_bubble: got %b want 1", bubble_ex); end
    if (stall_id !== 1'b0) begin n_fail++; $display("FAIL rd_stall_id: got %b want 0", stall_id); end
    if (stall_if !== 1'b0) begin n_fail++; $display("FAIL rd_stall_if: got %b want 0", stall_if); end
    run_cycle();
    idle();
    n_cmp += 2;
    if (flush_cnt !== CNT_W'(1)) begin n_fail++; $display("FAIL rd_flush_cnt: got %0d want 1", flush_cnt); end
    if (stall_cnt !== '0) begin n_fail++; $display("FAIL rd_stall_cnt: got %0d want 0", stall_cnt); end
    for (int i = 0; i < DEPTH; i++) run_cycle();
  endtask

  task automatic test_priority();
    int cnt;
    do_reset();
    set_id(1'b1, '0, 1'b0, '0, 1'b0, 5'd7, 1'b1, 1'b0);
    run_cycle();
    idle();
    run_cycle();
    set_id(1'b1, '0, 1'b0, '0, 1'b0, 5'd7, 1'b1, 1'b0);
    run_cycle();
    set_id(1'b1, 5'd7, 1'b1, '0, 1'b0, 5'd10, 1'b1, 1'b0);
    stage_data[0*XLEN +: XLEN] = 32'hA0;
    stage_data[1*XLEN +: XLEN] = 32'hA1;
    stage_data[2*XLEN +: XLEN] = 32'hA2;
    #1;
`ifdef HAZARD_FWD_EN
    n_cmp += 3;
    if (rs1_fwd_sel !== 3'd1) begin n_fail++; $display("FAIL prio_sel: got %0d want 1", rs1_fwd_sel); end
    if (rs1_fwd_data !== 32'hA0) begin n_fail++; $display("FAIL prio_data: got %h want a0", rs1_fwd_data); end
    if (stall_id !== 1'b0) begin n_fail++; $display("FAIL prio_stall: got %b want 0", stall_id); end
    issue(10);
`else
    cnt = 0;
    for (int i = 0; i < 10 && stall_id === 1'b1; i++) begin
      cnt++;
      run_cycle();
    end
    n_cmp++;
    if (cnt != DEPTH) begin n_fail++; $display("FAIL prio_stall_len: got %0d want %0d", cnt, DEPTH); end
    issue(2);
`endif
    run_cycle();
  endtask

  task automatic test_counters();
    exp_t e;
    do_reset();
    m_stalls_total = 0;
    set_id(1'b1, 5'd6, 1'b1, '0, 1'b0, 5'd6, 1'b1, 1'b1);
    for (int i = 0; i < 4000 && m_stalls_total < CMAX + 4; i++) run_cycle();
    n_cmp += 2;
    if (m_stalls_total < CMAX + 4) begin n_fail++; $display("FAIL cnt_budget: got %0d stalls want %0d", m_stalls_total, CMAX + 4); end
    if (stall_cnt !== {CNT_W{1'b1}}) begin n_fail++; $display("FAIL cnt_saturate: got %0d want %0d", stall_cnt, CMAX); end
    for (int i = 0; i < 2 * DEPTH + 2; i++) begin
      e = predict();
      if (e.stall) break;
      run_cycle();
    end
    #1;
    n_cmp++;
    if (stall_id !== 1'b1) begin n_fail++; $display("FAIL rst_pre_stall: got %b want 1", stall_id); end
    reset = 1'b1;
    #1;
    n_cmp += 5;
    if (stall_id !== 1'b0) begin n_fail++; $display("FAIL rst_stall_id: got %b want 0", stall_id); end
    if (stall_if !== 1'b0) begin n_fail++; $display("FAIL rst_stall_if: got %b want 0", stall_if); end
    if (bubble_ex !== 1'b0) begin n_fail++; $display("FAIL rst_bubble: got %b want 0", bubble_ex); end
    if (stall_cnt !== '0) begin n_fail++; $display("FAIL rst_stall_cnt: got %0d want 0", stall_cnt); end
    if (flush_cnt !== '0) begin n_fail++; $display("FAIL rst_flush_cnt: got %0d want 0", flush_cnt); end
    run_cycle();
    reset = 1'b0;
    idle();
    run_cycle();
    run_cycle();
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_x0();
    test_redirect();
    test_priority();
    test_counters();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
